// File: rtl/rtclock_pkg.sv
// Shared real-time-clock types and widths, used by rtclock and its downstream stamping blocks.
package rtclock_pkg;

    localparam int SEC_W  = 48;
    localparam int NSEC_W = 30;
    localparam int SEQ_W  = 16;

    localparam logic [NSEC_W-1:0] NSEC_MODULO = 30'd1000000000;

    typedef struct packed {
        logic [SEC_W-1:0]  sec;
        logic [NSEC_W-1:0] nsec;
    } rtc_stamp_t;

    typedef struct packed {
        rtc_stamp_t        stamp;
        logic [SEQ_W-1:0]  seq;
    } event_entry_t;

    localparam int ENTRY_W = $bits(event_entry_t);

    // Step a timestamp back by delta ns (delta < NSEC_MODULO); seconds wrap modulo 2^SEC_W.
    function automatic rtc_stamp_t stamp_subtract_ns(input rtc_stamp_t t,
                                                     input logic [NSEC_W-1:0] delta);
        rtc_stamp_t r;
        if (t.nsec >= delta) begin
            r.sec  = t.sec;
            r.nsec = t.nsec - delta;
        end else begin
            r.sec  = t.sec - SEC_W'(1);
            r.nsec = t.nsec + (NSEC_MODULO - delta);
        end
        return r;
    endfunction

endpackage

// File: rtl/rtclock_stamp_fifo.sv
// First-word-fall-through FIFO: array storage with a registered head stage; accepts a push
// while full when the head is popped in the same cycle.
module rtclock_stamp_fifo #(
    parameter int WIDTH = 94,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_accept,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    level_reg;
    logic             head_valid_reg;
    logic [WIDTH-1:0] head_reg;

    logic             pop;
    logic             full;
    logic             load;
    logic [CW-1:0]    mem_cnt;

    // level counts the head register too, so the array holds level minus the head.
    assign pop         = head_valid_reg & out_ready;
    assign full        = (level_reg == CW'(DEPTH));
    assign push_accept = push & (~full | pop);
    assign mem_cnt     = level_reg - CW'(head_valid_reg);
    assign load        = (~head_valid_reg | pop) & (mem_cnt != '0);

    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            head_valid_reg <= 1'b0;
            head_reg       <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            // A slot being loaded was written on an earlier edge, never the one written now.
            if (load) begin
                head_reg   <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (load) begin
                head_valid_reg <= 1'b1;
            end else if (pop) begin
                head_valid_reg <= 1'b0;
            end
            level_reg <= level_reg + CW'(push_accept) - CW'(pop);
        end
    end

    assign out_valid = head_valid_reg;
    assign out_data  = head_reg;
    assign level     = level_reg;

endmodule

// File: rtl/rtclock_event_stamp.sv
// Timestamps rising edges of an asynchronous event with the rtclock time, compensating for
// synchroniser delay, and queues {stamp, seq} entries in a FWFT FIFO.
module rtclock_event_stamp
    import rtclock_pkg::*;
#(
    parameter int DEPTH             = 16,
    parameter int SYNC_STAGES       = 2,
    parameter int C_CLK_TO_NS_RATIO = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [SEC_W-1:0]         sec,
    input  logic [NSEC_W-1:0]        nsec,
    input  logic                     event_in,
    input  logic                     enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEC_W-1:0]         out_sec,
    output logic [NSEC_W-1:0]        out_nsec,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              overflow_cnt
);

    localparam logic [NSEC_W-1:0] COMP_NS = NSEC_W'(SYNC_STAGES * C_CLK_TO_NS_RATIO);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   sync_d_reg;
    logic                   edge_det;
    logic                   capture;

    logic [SEQ_W-1:0]       seq_reg;
    logic [15:0]            overflow_cnt_reg;

    rtc_stamp_t             now;
    event_entry_t           push_entry;
    event_entry_t           head_entry;
    logic                   push_accept;
    logic [ENTRY_W-1:0]     head_bits;

    assign sync_next = {sync_reg[SYNC_STAGES-2:0], event_in};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg   <= '0;
            sync_d_reg <= 1'b0;
        end else begin
            sync_reg   <= sync_next;
            sync_d_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_reg[SYNC_STAGES-1] & ~sync_d_reg;
    assign capture  = edge_det & enable;

    // The time seen now is SYNC_STAGES cycles after the event was first sampled.
    assign now              = {sec, nsec};
    assign push_entry.stamp = stamp_subtract_ns(now, COMP_NS);
    assign push_entry.seq   = seq_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            seq_reg          <= '0;
            overflow_cnt_reg <= '0;
        end else begin
            if (capture) begin
                seq_reg <= seq_reg + SEQ_W'(1);
            end
            if (capture && !push_accept && overflow_cnt_reg != 16'hFFFF) begin
                overflow_cnt_reg <= overflow_cnt_reg + 16'd1;
            end
        end
    end

    rtclock_stamp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push        (capture),
        .push_data   (push_entry),
        .push_accept (push_accept),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (head_bits),
        .level       (level)
    );

    assign head_entry   = head_bits;
    assign out_sec      = head_entry.stamp.sec;
    assign out_nsec     = head_entry.stamp.nsec;
    assign out_seq      = head_entry.seq;
    assign overflow_cnt = overflow_cnt_reg;

endmodule

// File: tb/tb_rtclock_event_stamp.sv
// Scoreboard bench for rtclock_event_stamp: stimulus queues hand-computed entries, a monitor
// compares them as the DUT pops its head.
module tb_rtclock_event_stamp;
    import rtclock_pkg::*;

    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [47:0]       sec = '0;
    logic [29:0]       nsec = '0;
    logic              event_in = 1'b0;
    logic              enable = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [47:0]       out_sec;
    logic [29:0]       out_nsec;
    logic [15:0]       out_seq;
    logic [4:0]        level;
    logic [15:0]       overflow_cnt;

    typedef struct packed {
        logic [47:0] sec;
        logic [29:0] nsec;
        logic [15:0] seq;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] exp_sec = '0;
    logic [29:0] exp_nsec = '0;
    logic [15:0] tb_seq = '0;

    always #5 clk = ~clk;

    rtclock_event_stamp #(
        .DEPTH             (DEPTH),
        .SYNC_STAGES       (2),
        .C_CLK_TO_NS_RATIO (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sec          (sec),
        .nsec         (nsec),
        .event_in     (event_in),
        .enable       (enable),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sec      (out_sec),
        .out_nsec     (out_nsec),
        .out_seq      (out_seq),
        .level        (level),
        .overflow_cnt (overflow_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: the head is popped on the next edge whenever valid & ready at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_entry: got seq %0d, expected no entry", out_seq);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("pop_seq%0d_sec", e.seq), 64'(out_sec), 64'(e.sec));
                    check($sformatf("pop_seq%0d_nsec", e.seq), 64'(out_nsec), 64'(e.nsec));
                    check($sformatf("pop_seq%0d_seq", e.seq), 64'(out_seq), 64'(e.seq));
                end
            end
        end
    end

    task automatic set_time(input logic [47:0] s, input logic [29:0] ns,
                            input logic [47:0] es, input logic [29:0] ens);
        @(posedge clk);
        #1;
        sec      = s;
        nsec     = ns;
        exp_sec  = es;
        exp_nsec = ens;
    endtask

    // One-cycle-high pulse; returns just after edge k (the first sampling edge).
    task automatic pulse(input bit accept);
        @(posedge clk);
        #1 event_in = 1'b1;
        if (enable) begin
            if (accept) exp_q.push_back('{sec: exp_sec, nsec: exp_nsec, seq: tb_seq});
            tb_seq = tb_seq + 16'd1;
        end
        @(posedge clk);
        #1 event_in = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 out_ready = r;
    endtask

    task automatic wait_empty(input string name);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (level == 0 && !out_valid) break;
        end
        check({name, "_level"}, 64'(level), 64'd0);
        check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ovf", 64'(overflow_cnt), 64'd0);
        check("rst_sec", 64'(out_sec), 64'd0);
        check("rst_nsec", 64'(out_nsec), 64'd0);
        check("rst_seq", 64'(out_seq), 64'd0);

        // Clean capture and event-to-valid latency of 3 cycles.
        set_time(48'd5, 30'd1000, 48'd5, 30'd984);
        pulse(1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid_k2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_valid_k3", 64'(out_valid), 64'd1);
        set_ready(1'b1);
        wait_empty("clean");

        // Borrow and seconds wrap.
        set_time(48'd7, 30'd8, 48'd6, 30'd999999992);
        pulse(1'b1);
        wait_empty("borrow");
        set_time(48'd0, 30'd0, 48'hFFFF_FFFF_FFFF, 30'd999999984);
        pulse(1'b1);
        wait_empty("wrap");

        // Overflow from a fresh reset: 20 events, 16 stored.
        set_ready(1'b0);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        tb_seq = '0;
        set_time(48'd9, 30'd500, 48'd9, 30'd484);
        for (int i = 0; i < 20; i++) pulse(i < DEPTH);
        settle(4);
        check("ovf_level", 64'(level), 64'd16);
        check("ovf_cnt", 64'(overflow_cnt), 64'd4);
        set_ready(1'b1);
        wait_empty("ovf_drain");
        pulse(1'b1);
        wait_empty("after_ovf");

        // Full FIFO with a pop coinciding with the push.
        set_ready(1'b0);
        set_time(48'd11, 30'd16, 48'd11, 30'd0);
        for (int i = 0; i < DEPTH; i++) pulse(1'b1);
        settle(4);
        check("full_level", 64'(level), 64'd16);
        pulse(1'b1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("fullpop_level", 64'(level), 64'd16);
        check("fullpop_ovf", 64'(overflow_cnt), 64'd4);
        set_ready(1'b1);
        wait_empty("fullpop_drain");

        // Reset mid-operation with 5 queued entries.
        set_ready(1'b0);
        set_time(48'd13, 30'd40, 48'd13, 30'd24);
        for (int i = 0; i < 5; i++) pulse(1'b1);
        settle(4);
        check("pre_rst_level", 64'(level), 64'd5);
        @(posedge clk);
        #1 resetn = 1'b0;
        exp_q.delete();
        tb_seq = '0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_ovf", 64'(overflow_cnt), 64'd0);

        // Disabled edges are ignored; first enabled event after reset gets seq 0.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse(1'b1);
        settle(4);
        check("dis_level", 64'(level), 64'd0);
        check("dis_valid", 64'(out_valid), 64'd0);
        check("dis_ovf", 64'(overflow_cnt), 64'd0);
        enable = 1'b1;
        set_time(48'd20, 30'd100, 48'd20, 30'd84);
        set_ready(1'b1);
        pulse(1'b1);
        wait_empty("reenable");

        check("final_ovf", 64'(overflow_cnt), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rtclock_event_stamp.md
# rtclock_event_stamp

Captures the real-time clock value (`sec`/`nsec` from the rtclock block) on rising edges of an asynchronous external event input and queues the timestamps in a small first-word-fall-through FIFO. It sits directly downstream of rtclock, in the `clk` domain. Synchroniser latency is removed, so each entry is the clock value at the cycle the event was first sampled. Entries carry a sequence number, so dropped events are visible to software.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `SYNC_STAGES`, 2: event synchroniser flops; minimum 2.
- `C_CLK_TO_NS_RATIO`, 8: ns per `clk` cycle; must equal rtclock's setting.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `sec` in 48: rtclock seconds.
- `nsec` in 30: rtclock nanoseconds, always < 1e9.
- `event_in` in 1: asynchronous event; a rising edge is an event.
- `enable` in 1: capture enable.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer pops the head when `out_valid & out_ready`.
- `out_sec` out 48: head seconds.
- `out_nsec` out 30: head nanoseconds.
- `out_seq` out 16: head sequence number.
- `level` out log2(DEPTH)+1: entries held.
- `overflow_cnt` out 16: dropped events; saturates at 0xFFFF.

## Operation
- Synchroniser chain: `s[0] <= event_in`, `s[i] <= s[i-1]`. Edge detect is `s[N-1] & ~s_d`, with `s_d` registered from `s[N-1]`. The chain runs regardless of `enable`.
- On a detected edge with `enable=1`:
  - Compute `COMP = SYNC_STAGES*C_CLK_TO_NS_RATIO` from the current `sec`/`nsec`.
  - If `nsec >= COMP`: stamp is `{sec, nsec-COMP}`.
  - Otherwise: stamp is `{sec-1, nsec+1000000000-COMP}`, with `sec` wrapping modulo 2^48 (0 becomes 0xFFFF_FFFF_FFFF).
  - Stamp the entry with the current `seq`, then increment `seq` (16-bit wrap). `seq` increments whether or not the push succeeds.
- Push succeeds if `level < DEPTH`, or if `level == DEPTH` and a pop occurs in the same cycle. Otherwise the event is dropped and `overflow_cnt` increments, saturating.
- Edges detected while `enable=0` are ignored: no `seq` change, no overflow count.
- `enable` has no effect on stored entries; it does not flush the FIFO.
- Pop happens when `out_valid & out_ready`. The next entry, or empty, is visible on the following cycle.
- Push and pop in the same cycle leave `level` unchanged.
- Head outputs (`out_sec`, `out_nsec`, `out_seq`) hold stable while `out_valid=1` and no pop occurs. They are don't-care while `out_valid=0`.
- Reset (`resetn=0` at a `clk` edge):
  - FIFO empties; `out_valid=0`, `level=0`.
  - `seq=0`, `overflow_cnt=0`.
  - Synchroniser and `s_d` are cleared. An `event_in` held high through reset produces an edge after release.
  - `out_sec`, `out_nsec` and `out_seq` reset to 0.
  - Reset applied mid-operation discards all entries with no partial outputs.

## Timing
- `event_in` is first sampled high at edge k. The edge is detected combinationally in the cycle after edge k+N-1, where N = `SYNC_STAGES`.
- Push happens at edge k+N, using the `sec`/`nsec` present in that cycle. Compensation is N cycles.
- `out_valid` rises after edge k+N+1. The head is registered, so event-to-`out_valid` latency is N+1 cycles.
- `level` and `overflow_cnt` update at the push/pop edge.
- Minimum event spacing for capture is 2 cycles (high and low each at least one sampled cycle). Pulses shorter than one `clk` period may be missed; that is accepted.
- Sustained throughput is one push and one pop per cycle.

## Structure
- Shared package `rtclock_pkg`:
  - Constant `NSEC_MODULO = 1000000000`.
  - Widths `SEC_W=48`, `NSEC_W=30`, `SEQ_W=16`.
  - Typedef `rtc_stamp_t {sec, nsec}`, shared with rtclock.
- One natural sub-module: `rtclock_stamp_fifo`, a FWFT synchronous FIFO with width and depth parameters, count output, and simultaneous push/pop when full.
- Synchroniser, compensation and counters live in the top module.

## Test plan
- Clean capture: `sec=5`, `nsec=1000` at the push cycle, `SYNC_STAGES=2`, ratio 8 → head `{5, 984}`, `seq=0`, `out_valid` exactly 3 cycles after first sample.
- Borrow: `sec=7`, `nsec=8` at push → `{6, 999999992}`. Wrap case: `sec=0`, `nsec=0` → `{0xFFFFFFFFFFFF, 999999984}`.
- Overflow: 20 events, `out_ready=0`, `DEPTH=16` → `level=16`, `overflow_cnt=4`. Draining yields `seq` 0..15. A following event gets `seq=20`.
- Full with simultaneous pop: `level=16`, event push coincides with `out_ready=1` → `level` stays 16, `overflow_cnt` unchanged.
- `enable=0`: 3 events → no entries, `seq` unchanged, `overflow_cnt=0`. Re-enable, then 1 event → `seq=0`.
- Reset mid-operation: 5 queued entries, pulse `resetn=0` for 1 cycle → `out_valid=0`, `level=0`, `overflow_cnt=0`. Next event gets `seq=0`.
